// File: rtl/wb_port_arbiter.sv
// Register-file writeback arbiter: merges core (A), link (L) and multi-cycle (M)
// write requests into one registered write port, with starvation promotion for A.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_idx,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        l_valid,
  input  logic [31:0] l_pc,
  output logic        l_ready,
  input  logic        m_valid,
  input  logic [4:0]  m_idx,
  input  logic [31:0] m_data,
  output logic        m_ready,
  output logic        wr_en,
  output logic [4:0]  wr_idx,
  output logic [31:0] wr_data,
  output logic        conflict
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0]  a_wait_q, a_wait_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_idx_q, wr_idx_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        conflict_q, conflict_d;
  logic        grant_a_s, grant_l_s, grant_m_s;
  logic        xfer_s;
  logic [4:0]  xfer_idx_s;
  logic [31:0] xfer_data_s;
  logic [1:0]  valid_cnt_s;

  // Grant selection: a starved A pre-empts the normal M > L > A order.
  always_comb begin
    grant_a_s = 1'b0;
    grant_l_s = 1'b0;
    grant_m_s = 1'b0;
    if (reset) begin
      grant_a_s = 1'b0;
    end else if (a_valid && (a_wait_q == LIMIT)) begin
      grant_a_s = 1'b1;
    end else if (m_valid) begin
      grant_m_s = 1'b1;
    end else if (l_valid) begin
      grant_l_s = 1'b1;
    end else if (a_valid) begin
      grant_a_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
    end
  end

  // Write payload, index-0 suppression, conflict detect and starvation counter.
  always_comb begin
    xfer_idx_s  = 5'd0;
    xfer_data_s = 32'h0;
    case ({grant_a_s, grant_l_s, grant_m_s})
      3'b100: begin
        xfer_idx_s  = a_idx;
        xfer_data_s = a_data;
      end
      3'b010: begin
        xfer_idx_s  = 5'd31;
        xfer_data_s = l_pc + 32'd4;
      end
      3'b001: begin
        xfer_idx_s  = m_idx;
        xfer_data_s = m_data;
      end
      default: begin
        xfer_idx_s  = 5'd0;
        xfer_data_s = 32'h0;
      end
    endcase
    xfer_s  = grant_a_s | grant_l_s | grant_m_s;
    wr_en_d = xfer_s && (xfer_idx_s != 5'd0);
    if (wr_en_d) begin
      wr_idx_d  = xfer_idx_s;
      wr_data_d = xfer_data_s;
    end else begin
      wr_idx_d  = wr_idx_q;
      wr_data_d = wr_data_q;
    end
    valid_cnt_s = {1'b0, a_valid} + {1'b0, l_valid} + {1'b0, m_valid};
    conflict_d  = (valid_cnt_s >= 2'd2);
    if (a_valid && !grant_a_s) begin
      a_wait_d = (a_wait_q == LIMIT) ? a_wait_q : (a_wait_q + 3'd1);
    end else begin
      a_wait_d = 3'd0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_wait_q   <= 3'd0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= 5'd0;
      wr_data_q  <= 32'h0;
      conflict_q <= 1'b0;
    end else begin
      a_wait_q   <= a_wait_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      conflict_q <= conflict_d;
    end
  end

  assign a_ready  = grant_a_s;
  assign l_ready  = grant_l_s;
  assign m_ready  = grant_m_s;
  assign wr_en    = wr_en_q;
  assign wr_idx   = wr_idx_q;
  assign wr_data  = wr_data_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (STARVE_LIMIT = 3).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, l_valid, m_valid;
  logic [4:0]  a_idx, m_idx;
  logic [31:0] a_data, l_pc, m_data;
  logic        a_ready, l_ready, m_ready;
  logic        wr_en, conflict;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_idx(a_idx), .a_data(a_data), .a_ready(a_ready),
    .l_valid(l_valid), .l_pc(l_pc), .l_ready(l_ready),
    .m_valid(m_valid), .m_idx(m_idx), .m_data(m_data), .m_ready(m_ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [31:0] lp,
                       input logic mv, input logic [4:0] mi, input logic [31:0] md);
    a_valid = av; a_idx = ai; a_data = ad;
    l_valid = lv; l_pc = lp;
    m_valid = mv; m_idx = mi; m_data = md;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 5'd5, 32'h55, 1'b1, 32'h100, 1'b1, 5'd6, 32'h66);
    @(negedge clk); #1;
    n_cmp++;
    if ({a_ready, l_ready, m_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 000", {a_ready, l_ready, m_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, conflict} !== {1'b0, 5'd0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_outputs: got en=%b idx=%0d data=%h cf=%b want 0/0/0/0",
                         wr_en, wr_idx, wr_data, conflict);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_single_a();
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    n_cmp++;
    if ({a_ready, l_ready, m_ready} !== 3'b100) begin
      n_fail++; $display("FAIL single_a_ready: got %b want 100", {a_ready, l_ready, m_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, conflict} !== {1'b1, 5'd5, 32'h1234, 1'b0}) begin
      n_fail++; $display("FAIL single_a_write: got en=%b idx=%0d data=%h cf=%b want 1/5/1234/0",
                         wr_en, wr_idx, wr_data, conflict);
    end
  endtask

  task automatic test_idle();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    n_cmp++;
    if ({a_ready, l_ready, m_ready} !== 3'b000) begin
      n_fail++; $display("FAIL idle_ready: got %b want 000", {a_ready, l_ready, m_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, conflict} !== {1'b0, 5'd5, 32'h1234, 1'b0}) begin
      n_fail++; $display("FAIL idle_hold: got en=%b idx=%0d data=%h cf=%b want 0/5/1234/0",
                         wr_en, wr_idx, wr_data, conflict);
    end
  endtask

  task automatic test_link();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0);
    #1;
    n_cmp++;
    if ({a_ready, l_ready, m_ready} !== 3'b010) begin
      n_fail++; $display("FAIL link_ready: got %b want 010", {a_ready, l_ready, m_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data} !== {1'b1, 5'd31, 32'h0}) begin
      n_fail++; $display("FAIL link_wrap: got en=%b idx=%0d data=%h want 1/31/00000000",
                         wr_en, wr_idx, wr_data);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h00000100, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data} !== {1'b1, 5'd31, 32'h104}) begin
      n_fail++; $display("FAIL link_plus4: got en=%b idx=%0d data=%h want 1/31/104",
                         wr_en, wr_idx, wr_data);
    end
  endtask

  task automatic test_all_three();
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 32'h40, 1'b1, 5'd7, 32'hAAAA);
    #1;
    n_cmp++;
    if ({a_ready, l_ready, m_ready} !== 3'b001) begin
      n_fail++; $display("FAIL all3_ready: got %b want 001", {a_ready, l_ready, m_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, conflict} !== {1'b1, 5'd7, 32'hAAAA, 1'b1}) begin
      n_fail++; $display("FAIL all3_write: got en=%b idx=%0d data=%h cf=%b want 1/7/aaaa/1",
                         wr_en, wr_idx, wr_data, conflict);
    end
    idle_cycle();
    n_cmp++;
    if (conflict !== 1'b0) begin
      n_fail++; $display("FAIL conflict_clear: got %b want 0", conflict);
    end
  endtask

  task automatic test_l_over_a();
    @(negedge clk);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 32'h40, 1'b0, 5'd0, 32'h0);
    #1;
    n_cmp++;
    if ({a_ready, l_ready, m_ready} !== 3'b010) begin
      n_fail++; $display("FAIL l_over_a_ready: got %b want 010", {a_ready, l_ready, m_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, conflict} !== {1'b1, 5'd31, 32'h44, 1'b1}) begin
      n_fail++; $display("FAIL l_over_a_write: got en=%b idx=%0d data=%h cf=%b want 1/31/44/1",
                         wr_en, wr_idx, wr_data, conflict);
    end
    idle_cycle();
  endtask

  task automatic test_starvation();
    logic [2:0] exp_rdy [5];
    exp_rdy = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 32'h0, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({a_ready, l_ready, m_ready} !== exp_rdy[i]) begin
        n_fail++; $display("FAIL starve_ready[%0d]: got %b want %b", i,
                           {a_ready, l_ready, m_ready}, exp_rdy[i]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (exp_rdy[i] == 3'b100) begin
        if ({wr_en, wr_idx, wr_data, conflict} !== {1'b1, 5'd3, 32'h33, 1'b1}) begin
          n_fail++; $display("FAIL starve_write[%0d]: got en=%b idx=%0d data=%h cf=%b want 1/3/33/1",
                             i, wr_en, wr_idx, wr_data, conflict);
        end
      end else begin
        if ({wr_en, wr_idx, wr_data, conflict} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
          n_fail++; $display("FAIL starve_write[%0d]: got en=%b idx=%0d data=%h cf=%b want 1/9/99/1",
                             i, wr_en, wr_idx, wr_data, conflict);
        end
      end
    end
    idle_cycle();
  endtask

  task automatic test_r0();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    #1;
    n_cmp++;
    if ({a_ready, l_ready, m_ready} !== 3'b001) begin
      n_fail++; $display("FAIL r0_ready: got %b want 001", {a_ready, l_ready, m_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data} !== {1'b0, 5'd9, 32'h99}) begin
      n_fail++; $display("FAIL r0_suppress: got en=%b idx=%0d data=%h want 0/9/99",
                         wr_en, wr_idx, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_idx  [4];
    logic [31:0] exp_data [4];
    exp_idx  = '{5'd1, 5'd2, 5'd31, 5'd4};
    exp_data = '{32'h11, 32'h22, 32'h204, 32'h44};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      case (i)
        0: drive(1'b1, 5'd1, 32'h11, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        1: drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd2, 32'h22);
        2: drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h200, 1'b0, 5'd0, 32'h0);
        default: drive(1'b1, 5'd4, 32'h44, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
      endcase
      @(posedge clk); #1;
      n_cmp++;
      if ({wr_en, wr_idx, wr_data} !== {1'b1, exp_idx[i], exp_data[i]}) begin
        n_fail++; $display("FAIL b2b[%0d]: got en=%b idx=%0d data=%h want 1/%0d/%h",
                           i, wr_en, wr_idx, wr_data, exp_idx[i], exp_data[i]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_mid_reset();
    logic [2:0] exp_rdy [4];
    exp_rdy = '{3'b001, 3'b001, 3'b001, 3'b100};
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 32'h0, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_cmp++;
      if (m_ready !== 1'b1) begin
        n_fail++; $display("FAIL mreset_pre[%0d]: got m_ready=%b want 1", i, m_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_ready, l_ready, m_ready} !== 3'b000) begin
      n_fail++; $display("FAIL mreset_ready: got %b want 000", {a_ready, l_ready, m_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, conflict} !== {1'b0, 5'd0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL mreset_outputs: got en=%b idx=%0d data=%h cf=%b want 0/0/0/0",
                         wr_en, wr_idx, wr_data, conflict);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({a_ready, l_ready, m_ready} !== exp_rdy[i]) begin
        n_fail++; $display("FAIL mreset_post[%0d]: got %b want %b", i,
                           {a_ready, l_ready, m_ready}, exp_rdy[i]);
      end
      @(posedge clk);
    end
    idle_cycle();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_single_a();
    test_idle();
    test_link();
    test_all_three();
    test_l_over_a();
    test_starvation();
    test_r0();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
